// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer between the ProgramCounter and instruction memory.
// Holds the fetched word until retire, then selects the next PC; otherwise freezes the PC.
module fetch_sequencer #(
  parameter int unsigned TIMEOUT = 16,  // valid range 2..255
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      currentPC,
  output logic [31:0]      nextPC,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ack,
  input  logic             branch_taken,
  input  logic [31:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_target,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  output logic             fetch_error,
  output logic             misalign_error,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StError} state_e;

  localparam logic [7:0]       WaitLast = 8'(TIMEOUT - 1);
  localparam logic [7:0]       WaitOne  = 8'd1;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e            state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic [31:0]       instr_q, instr_d;
  logic              ferr_q, ferr_d;
  logic              merr_q, merr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [31:0]       pc4;
  logic [31:0]       target;

  // Target priority: jr > jump > branch > sequential.
  always_comb begin
    pc4 = currentPC + 32'd4;
    if (jr) begin
      target = jr_target;
    end else if (jump) begin
      target = {pc4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      target = pc4 + (branch_offset << 2);
    end else begin
      target = pc4;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    instr_d     = instr_q;
    ferr_d      = ferr_q;
    merr_d      = merr_q;
    count_d     = count_q;
    nextPC      = currentPC;
    imem_req    = 1'b0;
    instr_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_d = imem_rdata;
          wait_d  = 8'd0;
          state_d = StIssue;
        end else begin
          wait_d = wait_q + WaitOne;
          if (wait_q == WaitLast) begin
            ferr_d  = 1'b1;
            state_d = StError;
          end
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
          // A misaligned target never reaches the PC.
          if (target[1:0] != 2'b00) begin
            merr_d  = 1'b1;
            state_d = StError;
          end else begin
            nextPC  = target;
            count_d = count_q + CntOne;
            state_d = StFetch;
          end
        end
      end
      StError: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wait_q  <= 8'd0;
      instr_q <= 32'd0;
      ferr_q  <= 1'b0;
      merr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      ferr_q  <= ferr_d;
      merr_q  <= merr_d;
      count_q <= count_d;
    end
  end

  assign imem_addr      = currentPC;
  assign instr          = instr_q;
  assign fetch_error    = ferr_q;
  assign misalign_error = merr_q;
  assign instr_count    = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural model checked every cycle, directed literal
// checks for the documented scenarios, then randomized traffic.
module tb_fetch_sequencer;

  localparam int unsigned TIMEOUT = 6;
  localparam int unsigned CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      currentPC;
  logic [31:0]      nextPC;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ack;
  logic             branch_taken;
  logic [31:0]      branch_offset;
  logic             jump;
  logic [25:0]      jump_target;
  logic             jr;
  logic [31:0]      jr_target;
  logic             fetch_error;
  logic             misalign_error;
  logic [CNT_W-1:0] instr_count;

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  // Stand-in ProgramCounter: follows nextPC, or is forced for directed tests.
  logic        pc_follow = 1'b0;
  logic [31:0] pc_force  = 32'd0;
  logic [31:0] pc_reg    = 32'd0;
  assign currentPC = pc_reg;
  always @(posedge clk) pc_reg <= pc_follow ? nextPC : pc_force;

  always #5 clk = ~clk;

  fetch_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .currentPC      (currentPC),
    .nextPC         (nextPC),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ack      (instr_ack),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_target    (jump_target),
    .jr             (jr),
    .jr_target      (jr_target),
    .fetch_error    (fetch_error),
    .misalign_error (misalign_error),
    .instr_count    (instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 waiting on memory, 2 holding an instruction, 3 dead.
  int               m_mode;
  int               m_wait;
  logic [31:0]      m_instr;
  logic             m_ferr;
  logic             m_merr;
  logic [CNT_W-1:0] m_count;

  function automatic logic [31:0] ref_target();
    logic [31:0] pc4;
    pc4 = currentPC + 32'd4;
    if (jr)           return jr_target;
    if (jump)         return {pc4[31:28], jump_target, 2'b00};
    if (branch_taken) return pc4 + branch_offset * 32'd4;
    return pc4;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode  <= 0;
      m_wait  <= 0;
      m_instr <= 32'd0;
      m_ferr  <= 1'b0;
      m_merr  <= 1'b0;
      m_count <= '0;
    end else begin
      case (m_mode)
        0: m_mode <= 1;
        1: begin
          if (imem_ready) begin
            m_instr <= imem_rdata;
            m_wait  <= 0;
            m_mode  <= 2;
          end else if (m_wait + 1 >= int'(TIMEOUT)) begin
            m_mode <= 3;
            m_ferr <= 1'b1;
          end else begin
            m_wait <= m_wait + 1;
          end
        end
        2: begin
          if (instr_ack) begin
            if (ref_target() % 4 != 0) begin
              m_mode <= 3;
              m_merr <= 1'b1;
            end else begin
              m_count <= m_count + 1'b1;
              m_mode  <= 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_next;
    if (check_en) begin
      exp_next = currentPC;
      if (m_mode == 2 && instr_ack && ref_target() % 4 == 0) exp_next = ref_target();
      chk("nextPC",         nextPC,                 exp_next);
      chk("imem_req",       32'(imem_req),          32'(m_mode == 1));
      chk("imem_addr",      imem_addr,              currentPC);
      chk("instr_valid",    32'(instr_valid),       32'(m_mode == 2));
      chk("instr",          instr,                  m_instr);
      chk("fetch_error",    32'(fetch_error),       32'(m_ferr));
      chk("misalign_error", 32'(misalign_error),    32'(m_merr));
      chk("instr_count",    32'(instr_count),       32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_issue();
    int n = 0;
    do begin
      tick();
      at_neg();
      n++;
    end while (!instr_valid && n < 20);
    chk("reach_issue", 32'(instr_valid), 32'd1);
  endtask

  task automatic retire_check(input string name, input logic [31:0] exp);
    wait_issue();
    tick();
    instr_ack = 1'b1;
    at_neg();
    chk(name, nextPC, exp);
    tick();
    instr_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    reset         = 1'b1;
    imem_ready    = 1'b0;
    imem_rdata    = 32'd0;
    instr_ack     = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'd0;
    jump          = 1'b0;
    jump_target   = 26'd0;
    jr            = 1'b0;
    jr_target     = 32'd0;
    #2 reset = 1'b0;
    #1 check_en = 1'b1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_imem_req",    32'(imem_req),    32'd0);
    chk("rst_instr",       instr,            32'd0);
    chk("rst_count",       32'(instr_count), 32'd0);

    // Sequential run from PC 0 with memory and downstream always ready.
    imem_ready = 1'b1;
    instr_ack  = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (3) tick();
    pc_follow = 1'b1;
    reset     = 1'b1;
    at_neg();
    chk("req_low_after_release", 32'(imem_req), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      at_neg();
      if (k == 0) chk("req_first_high", 32'(imem_req), 32'd1);
      if (k % 2 == 1) chk("seq_nextpc", nextPC, 32'(4 * ((k + 1) / 2)));
    end
    tick();
    at_neg();
    chk("count_after_three", 32'(instr_count), 32'd3);

    // Branch, jump and jr priority.
    tick();
    instr_ack     = 1'b0;
    pc_follow     = 1'b0;
    pc_force      = 32'h0040_0010;
    branch_taken  = 1'b1;
    branch_offset = 32'hFFFF_FFFE;
    retire_check("branch_back", 32'h0040_000C);
    branch_offset = 32'h0000_0003;
    retire_check("branch_fwd", 32'h0040_0020);
    pc_force    = 32'h1000_0000;
    jump        = 1'b1;
    jump_target = 26'h000_0040;
    retire_check("jump_over_branch", 32'h1000_0100);
    jr        = 1'b1;
    jr_target = 32'h0000_0080;
    retire_check("jr_over_jump", 32'h0000_0080);
    jr           = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    pc_force     = 32'hFFFF_FFFC;
    retire_check("pc4_wrap", 32'h0000_0000);

    // Misaligned jr target.
    pc_force  = 32'h1000_0000;
    jr        = 1'b1;
    jr_target = 32'h0000_0006;
    wait_issue();
    tick();
    instr_ack = 1'b1;
    at_neg();
    chk("misalign_nextpc", nextPC, 32'h1000_0000);
    tick();
    instr_ack = 1'b0;
    at_neg();
    chk("misalign_flag",  32'(misalign_error), 32'd1);
    chk("misalign_valid", 32'(instr_valid),    32'd0);
    chk("misalign_req",   32'(imem_req),       32'd0);
    tick();
    reset = 1'b0;
    #1 chk("misalign_cleared", 32'(misalign_error), 32'd0);

    // Hold in issue, then abort with an asynchronous reset.
    jr         = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    pc_force   = 32'h0000_1000;
    tick();
    reset = 1'b1;
    wait_issue();
    imem_rdata = 32'h0BAD_F00D;
    repeat (5) tick();
    at_neg();
    chk("hold_instr",  instr,            32'hDEAD_BEEF);
    chk("hold_nextpc", nextPC,           32'h0000_1000);
    chk("hold_valid",  32'(instr_valid), 32'd1);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_instr", instr,            32'd0);
    chk("async_rst_valid", 32'(instr_valid), 32'd0);

    // Memory timeout.
    imem_ready = 1'b0;
    tick();
    reset = 1'b1;
    repeat (TIMEOUT) tick();
    at_neg();
    chk("ferr_before_limit", 32'(fetch_error), 32'd0);
    tick();
    at_neg();
    chk("ferr_at_limit", 32'(fetch_error), 32'd1);
    chk("ferr_req",      32'(imem_req),    32'd0);
    chk("ferr_nextpc",   nextPC,           32'h0000_1000);
    tick();
    reset = 1'b0;
    #1 chk("ferr_cleared", 32'(fetch_error), 32'd0);
    tick();
    reset     = 1'b1;
    pc_follow = 1'b1;

    // Randomized traffic; model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!reset) begin
        reset = 1'b1;
      end else if (m_mode == 3 || $urandom_range(0, 199) == 0) begin
        reset = 1'b0;
      end
      r             = $urandom;
      imem_ready    = ($urandom_range(0, 9) < 7);
      imem_rdata    = $urandom;
      instr_ack     = ($urandom_range(0, 9) < 6);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_offset = {{16{r[15]}}, r[15:0]};
      jump          = ($urandom_range(0, 3) == 0);
      jump_target   = 26'($urandom);
      jr            = ($urandom_range(0, 3) == 0);
      jr_target     = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    end
    at_neg();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
